// File: rtl/gpio_controller_irq.sv
// GPIO controller with Avalon-MM CSRs, input synchroniser,
// edge-detect status (W1C) and a registered level interrupt.
//
// Ports:
//   clk_i, rst_n_i          clock, async active-low reset
//   amm_address_i[2:0]      CSR word address
//   amm_write_i/_writedata  CSR write strobe and data
//   amm_read_i              CSR read strobe
//   amm_readdata_o          read data, valid 1 cycle after read
//   amm_readdatavalid_o     read data qualifier
//   amm_waitrequest_o       always 0
//   gpio_buf_i              asynchronous pad inputs
//   gpio_buf_oe_o           per-pin output enable
//   gpio_buf_data_o         per-pin output data
//   irq_o                   |(IRQ_STATUS & IRQ_MASK), registered
//
// Optional feature macro: GPIO_DEBOUNCE_EN adds a per-pin
// stability filter between the synchroniser and DATA_IN.

module gpio_controller_irq #(
    parameter int AMM_WIDTH       = 32,
    parameter int GPIO_WIDTH      = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [2:0]            amm_address_i,
    input  logic                  amm_write_i,
    input  logic [AMM_WIDTH-1:0]  amm_writedata_i,
    input  logic                  amm_read_i,
    output logic [AMM_WIDTH-1:0]  amm_readdata_o,
    output logic                  amm_readdatavalid_o,
    output logic                  amm_waitrequest_o,
    input  logic [GPIO_WIDTH-1:0] gpio_buf_i,
    output logic [GPIO_WIDTH-1:0] gpio_buf_oe_o,
    output logic [GPIO_WIDTH-1:0] gpio_buf_data_o,
    output logic                  irq_o
);

    localparam int GW = GPIO_WIDTH;

    logic [GW-1:0] data_out_q;
    logic [GW-1:0] oe_q;
    logic [GW-1:0] rise_en_q;
    logic [GW-1:0] fall_en_q;
    logic [GW-1:0] mask_q;
    logic [GW-1:0] status_q;
    logic [GW-1:0] in_q;
    logic [GW-1:0] in_prev_q;
    logic [SYNC_STAGES-1:0][GW-1:0] sync_q;
    logic [GW-1:0] synced;
    logic [GW-1:0] wdata;
    logic [GW-1:0] clr;
    logic [GW-1:0] events;
    logic [GW-1:0] rd_mux;
    logic [AMM_WIDTH-1:0] rd_q;
    logic          rdv_q;
    logic          irq_q;

    // Upper write-data bits have no backing storage.
    logic unused_wd;
    assign unused_wd = ^amm_writedata_i;

    assign wdata  = amm_writedata_i[GW-1:0];
    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= gpio_buf_i;
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_q[i] <= sync_q[i-1];
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic [GW-1:0][CW-1:0] cnt_q;

    // A pin must disagree with in_q for DEBOUNCE_CYCLES
    // consecutive cycles before in_q follows it.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
            in_q  <= '0;
        end else begin
            for (int i = 0; i < GW; i++) begin
                if (synced[i] == in_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_MAX) begin
                    in_q[i]  <= synced[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end
`else
    localparam int UNUSED_DC = DEBOUNCE_CYCLES;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) in_q <= '0;
        else          in_q <= synced;
    end
`endif

    assign clr = (amm_write_i && amm_address_i == 3'd6)
               ? wdata : '0;

    assign events = (in_q & ~in_prev_q & rise_en_q)
                  | (~in_q & in_prev_q & fall_en_q);

    always_comb begin
        rd_mux = '0;
        unique case (amm_address_i)
            3'd0: rd_mux = data_out_q;
            3'd1: rd_mux = oe_q;
            3'd2: rd_mux = in_q;
            3'd3: rd_mux = rise_en_q;
            3'd4: rd_mux = fall_en_q;
            3'd5: rd_mux = mask_q;
            3'd6: rd_mux = status_q;
            3'd7: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_out_q <= '0;
            oe_q       <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            mask_q     <= '0;
            status_q   <= '0;
            in_prev_q  <= '0;
            rd_q       <= '0;
            rdv_q      <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            in_prev_q <= in_q;
            // Set beats clear so an event is never lost.
            status_q  <= (status_q & ~clr) | events;
            irq_q     <= |(status_q & mask_q);
            rdv_q     <= amm_read_i;
            if (amm_read_i)
                rd_q <= AMM_WIDTH'(rd_mux);
            if (amm_write_i) begin
                case (amm_address_i)
                    3'd0: data_out_q <= wdata;
                    3'd1: oe_q       <= wdata;
                    3'd3: rise_en_q  <= wdata;
                    3'd4: fall_en_q  <= wdata;
                    3'd5: mask_q     <= wdata;
                    3'd7: data_out_q <= data_out_q ^ wdata;
                    default: ;
                endcase
            end
        end
    end

    assign amm_readdata_o      = rd_q;
    assign amm_readdatavalid_o = rdv_q;
    assign amm_waitrequest_o   = 1'b0;
    assign gpio_buf_oe_o       = oe_q;
    assign gpio_buf_data_o     = data_out_q;
    assign irq_o               = irq_q;

endmodule

// File: tb/tb_gpio_controller_irq.sv
// Testbench for gpio_controller_irq: directed scenarios plus
// random CSR/pad traffic against a delay-line reference model.

module tb_gpio_controller_irq;

    localparam int AW = 32;
    localparam int GW = 16;
    localparam int SS = 2;
    localparam int DC = 8;
`ifdef GPIO_DEBOUNCE_EN
    localparam int FLT = DC;
`else
    localparam int FLT = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [2:0]    addr = '0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wd = '0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rdata;
    logic          rdv;
    logic          wreq;
    logic [GW-1:0] pad = '0;
    logic [GW-1:0] oe;
    logic [GW-1:0] dout;
    logic          irq;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gpio_controller_irq #(
        .AMM_WIDTH(AW), .GPIO_WIDTH(GW),
        .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .amm_address_i(addr), .amm_write_i(wr_en),
        .amm_writedata_i(wd), .amm_read_i(rd_en),
        .amm_readdata_o(rdata), .amm_readdatavalid_o(rdv),
        .amm_waitrequest_o(wreq),
        .gpio_buf_i(pad), .gpio_buf_oe_o(oe),
        .gpio_buf_data_o(dout), .irq_o(irq)
    );

    // Reference model state
    logic [GW-1:0] m_out, m_oe, m_ren, m_fen, m_mask;
    logic [GW-1:0] m_stat, m_inq, m_prev;
    logic          m_irq, m_rdv;
    logic [AW-1:0] m_rd;
    logic [GW-1:0] hist[$];
    int            dcnt[GW];

    task automatic chk(input string tag,
                       input logic [AW-1:0] obs,
                       input logic [AW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h",
                   tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_out = '0; m_oe = '0; m_ren = '0; m_fen = '0;
        m_mask = '0; m_stat = '0; m_inq = '0; m_prev = '0;
        m_irq = 1'b0; m_rdv = 1'b0; m_rd = '0;
        hist = {};
        for (int i = 0; i < SS; i++) hist.push_back('0);
        for (int i = 0; i < GW; i++) dcnt[i] = 0;
    endtask

    function automatic logic [GW-1:0] reg_val(input logic [2:0] a);
        case (a)
            3'd0: return m_out;
            3'd1: return m_oe;
            3'd2: return m_inq;
            3'd3: return m_ren;
            3'd4: return m_fen;
            3'd5: return m_mask;
            3'd6: return m_stat;
            default: return '0;
        endcase
    endfunction

    // One clock edge of the behavioural model
    task automatic model_edge();
        logic [GW-1:0] syn, nq, ev, clr, w;
        logic ni;
        syn = hist[0];
        nq  = syn;
`ifdef GPIO_DEBOUNCE_EN
        nq = m_inq;
        for (int i = 0; i < GW; i++) begin
            if (syn[i] != m_inq[i]) begin
                dcnt[i]++;
                if (dcnt[i] == DC + 1) begin
                    nq[i] = syn[i];
                    dcnt[i] = 0;
                end
            end else begin
                dcnt[i] = 0;
            end
        end
`endif
        hist.push_back(pad);
        void'(hist.pop_front());
        w  = wd[GW-1:0];
        ev = (m_inq & ~m_prev & m_ren) | (~m_inq & m_prev & m_fen);
        clr = (wr_en && addr == 3'd6) ? w : '0;
        ni = |(m_stat & m_mask);
        m_rdv = rd_en;
        if (rd_en) m_rd = {16'h0, reg_val(addr)};
        m_stat = (m_stat & ~clr) | ev;
        m_prev = m_inq;
        m_inq  = nq;
        m_irq  = ni;
        if (wr_en) begin
            case (addr)
                3'd0: m_out  = w;
                3'd1: m_oe   = w;
                3'd3: m_ren  = w;
                3'd4: m_fen  = w;
                3'd5: m_mask = w;
                3'd7: m_out  = m_out ^ w;
                default: ;
            endcase
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk("data_o", {16'h0, dout}, {16'h0, m_out});
        chk("oe_o", {16'h0, oe}, {16'h0, m_oe});
        chk("irq_o", {31'h0, irq}, {31'h0, m_irq});
        chk("rdv_o", {31'h0, rdv}, {31'h0, m_rdv});
        chk("waitreq", {31'h0, wreq}, 32'h0);
        if (m_rdv) chk("rdata", rdata, m_rd);
    endtask

    task automatic cycn(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wr(input logic [2:0] a, input logic [AW-1:0] d);
        addr = a; wd = d; wr_en = 1'b1;
        cyc();
    endtask

    task automatic rd(input logic [2:0] a);
        addr = a; rd_en = 1'b1;
        cyc();
    endtask

    initial begin
        model_reset();
        // T1 reset
        #23;
        chk("rst_oe", {16'h0, oe}, 32'h0);
        chk("rst_data", {16'h0, dout}, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_rdv", {31'h0, rdv}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < 8; a++) begin
            rd(3'(a));
            chk("rst_read", rdata, 32'h0);
        end

        // T2 outputs and toggle
        wr(3'd1, 32'h0000_00FF);
        wr(3'd0, 32'h0000_A5A5);
        wr(3'd7, 32'h0000_0F0F);
        chk("t2_data", {16'h0, dout}, 32'h0000_AAAA);
        chk("t2_oe", {16'h0, oe}, 32'h0000_00FF);
        rd(3'd7);
        chk("t2_rd7", rdata, 32'h0);
        rd(3'd0);
        chk("t2_rd0", rdata, 32'h0000_AAAA);

        // T3 edges, latency, W1C
        pad = 16'h0002;
        cycn(SS + FLT + 4);
        wr(3'd3, 32'h1);
        wr(3'd4, 32'h2);
        wr(3'd5, 32'h3);
        pad = 16'h0003;
        cycn(SS + 2 + FLT);
        chk("t3_irq_early", {31'h0, irq}, 32'h0);
        cyc();
        chk("t3_irq_lat", {31'h0, irq}, 32'h1);
        pad = 16'h0000;
        cycn(SS + FLT + 4);
        rd(3'd6);
        chk("t3_stat", rdata, 32'h3);
        chk("t3_irq", {31'h0, irq}, 32'h1);
        wr(3'd6, 32'h1);
        rd(3'd6);
        chk("t3_stat_w1", rdata, 32'h2);
        chk("t3_irq_hold", {31'h0, irq}, 32'h1);
        wr(3'd6, 32'h2);
        cyc();
        chk("t3_irq_clr", {31'h0, irq}, 32'h0);

        // T4 set/clear race on bit 0
        pad = 16'h0001;
        cycn(SS + 1 + FLT);
        wr(3'd6, 32'h1);
        rd(3'd6);
        chk("t4_race", rdata, 32'h1);

        // T5 async reset mid-operation
        wr(3'd3, 32'hFFFF);
        wr(3'd4, 32'hFFFF);
        wr(3'd5, 32'hFFFF);
        pad = 16'hFFFE;
        cycn(SS + FLT + 4);
        pad = 16'hFFFF;
        cycn(SS + FLT + 4);
        chk("t5_irq_pre", {31'h0, irq}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("t5_irq", {31'h0, irq}, 32'h0);
        chk("t5_oe", {16'h0, oe}, 32'h0);
        chk("t5_data", {16'h0, dout}, 32'h0);
        chk("t5_rdv", {31'h0, rdv}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cycn(SS + FLT + 3);
        rd(3'd6);
        chk("t5_stat", rdata, 32'h0);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0)
                pad = 16'($urandom);
            addr  = 3'($urandom_range(0, 7));
            wd    = $urandom;
            wr_en = ($urandom_range(0, 2) == 0);
            rd_en = ($urandom_range(0, 1) == 0);
            if (addr == 3'd6 && $urandom_range(0, 1) == 0)
                wd = 32'h0;
            cyc();
        end

`ifdef GPIO_DEBOUNCE_EN
        // T6 debounce filter
        #2 rst_n = 1'b0;
        #1 model_reset();
        pad = 16'h0000;
        @(negedge clk);
        rst_n = 1'b1;
        wr(3'd3, 32'h1);
        cycn(SS + DC + 4);
        pad = 16'h0001;
        cycn(5);
        pad = 16'h0000;
        cycn(SS + DC + 4);
        rd(3'd2);
        chk("t6_glitch_in", rdata, 32'h0);
        rd(3'd6);
        chk("t6_glitch_st", rdata, 32'h0);
        pad = 16'h0001;
        cycn(12);
        cycn(SS + 3);
        rd(3'd2);
        chk("t6_level_in", rdata, 32'h1);
        rd(3'd6);
        chk("t6_level_st", rdata, 32'h1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
